onfi_nand_target: RTL

Cycle-accurate ONFI NAND target that responds to `nand_controller` over the shared asynchronous-style pin set: CLE_x, ALE_x, WE_x_n, RE_x_n, CE_x_n, WP_x_n, the 8-bit IO bus and RB_x_n. It decodes command, address and data cycles. It holds a small byte array organised as pages, and services RESET, READ ID, READ STATUS, READ PAGE, PROGRAM PAGE and ERASE with a busy phase signalled on RB_x_n. It replaces `dummy_dut` as the device-side end of the bench.

---
 rtl/onfi_nand_target.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/onfi_nand_target.sv
// rtl/onfi_nand_target.sv - ONFI NAND target: cycle decode, page array, busy timing; optional write protect via ONFI_TGT_WP_EN
module onfi_nand_target #(
  parameter int          PAGE_BYTES = 16,
  parameter int          NUM_PAGES  = 8,
  parameter int          T_R        = 20,
  parameter int          T_PROG     = 40,
  parameter int          T_ERS      = 60,
  parameter int          T_RST      = 10,
  parameter logic [7:0]  MFR_ID     = 8'h2C,
  parameter logic [7:0]  DEV_ID     = 8'hDA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CE_x_n,
  input  logic       CLE_x,
  input  logic       ALE_x,
  input  logic       WE_x_n,
  input  logic       RE_x_n,
  input  logic       WP_x_n,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_oe,
  output logic       RB_x_n
);

  localparam int CW = $clog2(PAGE_BYTES);
  localparam int RW = $clog2(NUM_PAGES);
  localparam int BW = 16;

  localparam logic [7:0] CMD_READ   = 8'h00;
  localparam logic [7:0] CMD_READ_C = 8'h30;
  localparam logic [7:0] CMD_PROG   = 8'h80;
  localparam logic [7:0] CMD_PROG_C = 8'h10;
  localparam logic [7:0] CMD_ERS    = 8'h60;
  localparam logic [7:0] CMD_ERS_C  = 8'hD0;
  localparam logic [7:0] CMD_STATUS = 8'h70;
  localparam logic [7:0] CMD_ID     = 8'h90;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DIN, S_WAIT_CONF, S_BUSY, S_DOUT
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_ID, OP_READ, OP_PROG, OP_ERASE, OP_RST
  } op_t;

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [1:0]      addr_cnt_q, addr_cnt_d;
  logic [7:0]      col_lo_q, col_lo_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [7:0]      id_addr_q, id_addr_d;
  logic [2:0]      id_idx_q, id_idx_d;
  logic            fail_q, fail_d;
  logic            status_mode_q, status_mode_d;
  logic            we_q, we_d;
  logic            re_q, re_d;
  logic [7:0]      io_out_q, io_out_d;
  logic            io_oe_q, io_oe_d;

  logic [7:0] mem_q  [NUM_PAGES][PAGE_BYTES];
  logic [7:0] page_q [PAGE_BYTES];

  logic page_fill, page_load, page_wr, mem_commit, mem_erase;
  logic we_edge, re_edge, cmd_cyc, addr_cyc, data_cyc;
  logic rdy;
  logic [7:0] status_byte, id_byte;

  logic wp_block, wp_bit;
`ifdef ONFI_TGT_WP_EN
  assign wp_block = ~WP_x_n;
  assign wp_bit   = WP_x_n;
`else
  logic wp_unused;
  assign wp_unused = WP_x_n;
  assign wp_block  = 1'b0;
  assign wp_bit    = 1'b1;
`endif

  assign we_edge  = ~CE_x_n & ~we_q & WE_x_n;
  assign re_edge  = ~CE_x_n & re_q & ~RE_x_n;
  assign cmd_cyc  = we_edge & CLE_x & ~ALE_x;
  assign addr_cyc = we_edge & ALE_x & ~CLE_x;
  assign data_cyc = we_edge & ~CLE_x & ~ALE_x;

  assign rdy         = (state_q != S_BUSY);
  assign status_byte = {wp_bit, rdy, rdy, 4'b0000, fail_q};

  assign io_out = io_out_q;
  assign io_oe  = io_oe_q & ~CLE_x & ~ALE_x;
  assign RB_x_n = rdy;

  // ID table lookup: selected by the ID address byte and the output index
  always_comb begin
    id_byte = 8'h00;
    if (id_addr_q == 8'h00) begin
      case (id_idx_q)
        3'd0:    id_byte = MFR_ID;
        3'd1:    id_byte = DEV_ID;
        default: id_byte = 8'h00;
      endcase
    end else if (id_addr_q == 8'h20) begin
      case (id_idx_q)
        3'd0:    id_byte = 8'h4F;
        3'd1:    id_byte = 8'h4E;
        3'd2:    id_byte = 8'h46;
        3'd3:    id_byte = 8'h49;
        default: id_byte = 8'h00;
      endcase
    end
  end

  // Next-state: busy countdown, then command/address/data decode, then output edges
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    addr_cnt_d    = addr_cnt_q;
    col_lo_d      = col_lo_q;
    col_d         = col_q;
    row_d         = row_q;
    id_addr_d     = id_addr_q;
    id_idx_d      = id_idx_q;
    fail_d        = fail_q;
    status_mode_d = status_mode_q;
    we_d          = WE_x_n;
    re_d          = RE_x_n;
    io_out_d      = io_out_q;
    io_oe_d       = io_oe_q;
    page_fill     = 1'b0;
    page_load     = 1'b0;
    page_wr       = 1'b0;
    mem_commit    = 1'b0;
    mem_erase     = 1'b0;

    if (RE_x_n || CE_x_n) io_oe_d = 1'b0;

    if (state_q == S_BUSY) begin
      if (cnt_q == '0) begin
        case (op_q)
          OP_READ:  begin page_load  = 1'b1; state_d = S_DOUT; end
          OP_PROG:  begin mem_commit = 1'b1; state_d = S_IDLE; end
          OP_ERASE: begin mem_erase  = 1'b1; state_d = S_IDLE; end
          default:  state_d = S_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q - BW'(1);
      end
    end

    if (cmd_cyc && (state_q != S_BUSY || io_in == CMD_STATUS || io_in == CMD_RESET)) begin
      status_mode_d = 1'b0;
      case (io_in)
        CMD_STATUS: status_mode_d = 1'b1;
        CMD_RESET: begin
          // abort wins over a completion landing in the same cycle
          page_load  = 1'b0;
          mem_commit = 1'b0;
          mem_erase  = 1'b0;
          state_d    = S_BUSY;
          op_d       = OP_RST;
          cnt_d      = BW'(T_RST - 1);
          col_d      = '0;
          row_d      = '0;
          fail_d     = 1'b0;
        end
        CMD_ID: begin
          state_d = S_ADDR; op_d = OP_ID; addr_cnt_d = 2'd0;
        end
        CMD_READ: begin
          state_d = S_ADDR; op_d = OP_READ; addr_cnt_d = 2'd0;
        end
        CMD_PROG: begin
          // unwritten columns stay FFh so the AND commit leaves them untouched
          state_d = S_ADDR; op_d = OP_PROG; addr_cnt_d = 2'd0;
          fail_d = 1'b0; page_fill = 1'b1;
        end
        CMD_ERS: begin
          state_d = S_ADDR; op_d = OP_ERASE; addr_cnt_d = 2'd0;
          fail_d = 1'b0;
        end
        CMD_READ_C: begin
          if (state_q == S_WAIT_CONF && op_q == OP_READ) begin
            state_d = S_BUSY; cnt_d = BW'(T_R - 1);
          end else begin
            state_d = S_IDLE; op_d = OP_NONE;
          end
        end
        CMD_PROG_C: begin
          if (state_q == S_DIN && op_q == OP_PROG && !wp_block) begin
            state_d = S_BUSY; cnt_d = BW'(T_PROG - 1);
          end else begin
            if (state_q == S_DIN && op_q == OP_PROG) fail_d = 1'b1;
            state_d = S_IDLE; op_d = OP_NONE;
          end
        end
        CMD_ERS_C: begin
          if (state_q == S_WAIT_CONF && op_q == OP_ERASE && !wp_block) begin
            state_d = S_BUSY; cnt_d = BW'(T_ERS - 1);
          end else begin
            if (state_q == S_WAIT_CONF && op_q == OP_ERASE) fail_d = 1'b1;
            state_d = S_IDLE; op_d = OP_NONE;
          end
        end
        default: begin
          state_d = S_IDLE; op_d = OP_NONE;
        end
      endcase
    end else if (addr_cyc && state_q == S_ADDR) begin
      case (op_q)
        OP_ID: begin
          id_addr_d = io_in; id_idx_d = 3'd0; state_d = S_DOUT;
        end
        OP_ERASE: begin
          row_d = RW'(io_in); state_d = S_WAIT_CONF;
        end
        default: begin
          addr_cnt_d = addr_cnt_q + 2'd1;
          case (addr_cnt_q)
            2'd0:    col_lo_d = io_in;
            2'd1:    col_d = CW'({io_in, col_lo_q});
            default: begin
              row_d   = RW'(io_in);
              state_d = (op_q == OP_READ) ? S_WAIT_CONF : S_DIN;
            end
          endcase
        end
      endcase
    end else if (data_cyc && state_q == S_DIN) begin
      page_wr = 1'b1;
      col_d   = col_q + CW'(1);
    end

    if (re_edge) begin
      if (status_mode_q) begin
        io_out_d = status_byte;
        io_oe_d  = 1'b1;
      end else if (state_q == S_DOUT) begin
        io_oe_d = 1'b1;
        if (op_q == OP_ID) begin
          io_out_d = id_byte;
          if (id_idx_q != 3'd4) id_idx_d = id_idx_q + 3'd1;
        end else begin
          io_out_d = page_q[col_q];
          col_d    = col_q + CW'(1);
        end
      end else if (state_q == S_ADDR && op_q == OP_READ && addr_cnt_q == 2'd0) begin
        // 00h after status mode with no address resumes the page read in place
        state_d  = S_DOUT;
        io_oe_d  = 1'b1;
        io_out_d = page_q[col_q];
        col_d    = col_q + CW'(1);
      end
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= OP_NONE;
      cnt_q         <= '0;
      addr_cnt_q    <= 2'd0;
      col_lo_q      <= 8'h00;
      col_q         <= '0;
      row_q         <= '0;
      id_addr_q     <= 8'h00;
      id_idx_q      <= 3'd0;
      fail_q        <= 1'b0;
      status_mode_q <= 1'b0;
      we_q          <= 1'b1;
      re_q          <= 1'b1;
      io_out_q      <= 8'h00;
      io_oe_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      addr_cnt_q    <= addr_cnt_d;
      col_lo_q      <= col_lo_d;
      col_q         <= col_d;
      row_q         <= row_d;
      id_addr_q     <= id_addr_d;
      id_idx_q      <= id_idx_d;
      fail_q        <= fail_d;
      status_mode_q <= status_mode_d;
      we_q          <= we_d;
      re_q          <= re_d;
      io_out_q      <= io_out_d;
      io_oe_q       <= io_oe_d;
    end
  end

  // Array and page register: no reset, and reset suppresses any pending update
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (page_fill) begin
        for (int i = 0; i < PAGE_BYTES; i++) page_q[i] <= 8'hFF;
      end else if (page_load) begin
        for (int i = 0; i < PAGE_BYTES; i++) page_q[i] <= mem_q[row_q][i];
      end else if (page_wr) begin
        page_q[col_q] <= io_in;
      end
      if (mem_commit) begin
        for (int i = 0; i < PAGE_BYTES; i++) mem_q[row_q][i] <= mem_q[row_q][i] & page_q[i];
      end else if (mem_erase) begin
        for (int i = 0; i < PAGE_BYTES; i++) mem_q[row_q][i] <= 8'hFF;
      end
    end
  end

endmodule
